// File: rtl/wb_sram_multibank.sv
`default_nettype none
// ============================================================================
// Module   : wb_sram_multibank
// Desc     : Wishbone slave presenting NUM_BANKS single-port SRAM macros as one
//            word-addressed region. Optional macro WB_SRAM_ERR_EN enables
//            wb_err_o for out-of-range and empty-mask writes.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sram_multibank #(
  parameter int          NUM_BANKS    = 2,
  parameter int          BANK_ADDR_WD = 8,
  parameter int          DATA_WD      = 32,
  parameter logic [31:0] ADDR_START   = 32'h3000_0000,
  parameter int          RD_LAT       = 1
) (
  input  logic                         wb_clk_i,
  input  logic                         rst_n,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [DATA_WD/8-1:0]         wb_sel_i,
  input  logic [31:0]                  wb_adr_i,
  input  logic [DATA_WD-1:0]           wb_dat_i,
  output logic [DATA_WD-1:0]           wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic [NUM_BANKS-1:0]         sram_csb_o,
  output logic                         sram_web_o,
  output logic [DATA_WD/8-1:0]         sram_wmask_o,
  output logic [BANK_ADDR_WD-1:0]      sram_addr_o,
  output logic [DATA_WD-1:0]           sram_din_o,
  input  logic [NUM_BANKS*DATA_WD-1:0] sram_dout_i
);

  localparam int                   c_bank_w       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [32:0]          c_region_bytes = 33'(NUM_BANKS) << (BANK_ADDR_WD + 2);
  localparam logic [1:0]           c_rd_lat       = 2'(RD_LAT);
  localparam logic [NUM_BANKS-1:0] c_bank_lsb     = NUM_BANKS'(1);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_write   = 2'd1;
  localparam logic [1:0] c_rd_wait = 2'd2;
  localparam logic [1:0] c_resp    = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              r_cnt;
  logic [c_bank_w-1:0]     r_bank;
  logic                    r_is_rd;
  logic                    r_err_resp;
  logic                    r_ack;
  logic                    r_err;
  logic [DATA_WD-1:0]      r_dat;
  logic [NUM_BANKS-1:0]    r_csb;
  logic                    r_web;
  logic [DATA_WD/8-1:0]    r_wmask;
  logic [BANK_ADDR_WD-1:0] r_addr;
  logic [DATA_WD-1:0]      r_din;

  logic [31:0]             w_offset;
  logic                    w_in_range;
  logic [c_bank_w-1:0]     w_bank;
  logic                    w_skip;
  logic                    w_err_req;

  assign w_offset   = wb_adr_i - ADDR_START;
  assign w_in_range = {1'b0, w_offset} < c_region_bytes;

  generate
    if (NUM_BANKS > 1) begin : g_bank_decode
      assign w_bank = w_offset[2+BANK_ADDR_WD +: c_bank_w];
    end else begin : g_bank_single
      assign w_bank = '0;
    end
  endgenerate

  // Requests that never touch a macro share the WRITE state as a fixed two-cycle path.
  assign w_skip = !w_in_range || (wb_we_i && (wb_sel_i == '0));

`ifdef WB_SRAM_ERR_EN
  assign w_err_req = w_skip;
`else
  assign w_err_req = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_idle;
      r_cnt      <= 2'd0;
      r_bank     <= '0;
      r_is_rd    <= 1'b0;
      r_err_resp <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_csb      <= '1;
      r_web      <= 1'b1;
      r_wmask    <= '0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        c_idle: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_cnt      <= 2'd0;
            r_bank     <= w_bank;
            r_is_rd    <= !wb_we_i;
            r_err_resp <= w_err_req;
            if (!w_skip) begin
              r_addr <= w_offset[2 +: BANK_ADDR_WD];
              r_csb  <= ~(c_bank_lsb << w_bank);
              if (wb_we_i) begin
                r_web   <= 1'b0;
                r_wmask <= wb_sel_i;
                r_din   <= wb_dat_i;
              end
            end
            r_state <= (wb_we_i || w_skip) ? c_write : c_rd_wait;
          end
        end
        c_write: begin
          if (!wb_cyc_i) begin
            r_csb   <= '1;
            r_web   <= 1'b1;
            r_state <= c_idle;
          end else if (r_cnt == 2'd0) begin
            r_csb <= '1;
            r_web <= 1'b1;
            r_cnt <= 2'd1;
          end else begin
            r_state <= c_resp;
            if (r_err_resp) begin
              r_err <= 1'b1;
            end else begin
              r_ack <= 1'b1;
              if (r_is_rd) r_dat <= '0;
            end
          end
        end
        c_rd_wait: begin
          if (!wb_cyc_i) begin
            r_csb   <= '1;
            r_state <= c_idle;
          end else if (r_cnt == c_rd_lat) begin
            r_dat   <= sram_dout_i[r_bank*DATA_WD +: DATA_WD];
            r_ack   <= 1'b1;
            r_state <= c_resp;
          end else begin
            r_csb <= '1;
            r_cnt <= r_cnt + 2'd1;
          end
        end
        c_resp: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign wb_dat_o     = r_dat;
  assign wb_ack_o     = r_ack;
  assign wb_err_o     = r_err;
  assign sram_csb_o   = r_csb;
  assign sram_web_o   = r_web;
  assign sram_wmask_o = r_wmask;
  assign sram_addr_o  = r_addr;
  assign sram_din_o   = r_din;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_multibank.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sram_multibank
// Desc     : Self-checking bench driving three controllers (RD_LAT 1..3) with
//            directed vectors, corner sequences and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sram_multibank;

  localparam logic [31:0] c_base   = 32'h3000_0000;
  localparam logic [31:0] c_region = 32'd2048;
  localparam logic [31:0] c_poison = 32'hBAD0_BAD0;
`ifdef WB_SRAM_ERR_EN
  localparam bit c_err_en = 1'b1;
`else
  localparam bit c_err_en = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [3:0]  sel   [3];
  logic [31:0] adr   [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic        ack   [3];
  logic        err   [3];
  logic [1:0]  csb   [3];
  logic        web   [3];
  logic [3:0]  wmask [3];
  logic [7:0]  saddr [3];
  logic [31:0] sdin  [3];
  logic [63:0] sdout [3];

  logic [31:0] ref_mem  [3][512];
  logic [31:0] last_dat [3];
  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mac  [2][256];
    logic [31:0] pipe [2][3];

    wb_sram_multibank #(.RD_LAT(g + 1)) u_dut (
      .wb_clk_i     (clk),
      .rst_n        (rst_n),
      .wb_cyc_i     (cyc[g]),
      .wb_stb_i     (stb[g]),
      .wb_we_i      (we[g]),
      .wb_sel_i     (sel[g]),
      .wb_adr_i     (adr[g]),
      .wb_dat_i     (wdat[g]),
      .wb_dat_o     (rdat[g]),
      .wb_ack_o     (ack[g]),
      .wb_err_o     (err[g]),
      .sram_csb_o   (csb[g]),
      .sram_web_o   (web[g]),
      .sram_wmask_o (wmask[g]),
      .sram_addr_o  (saddr[g]),
      .sram_din_o   (sdin[g]),
      .sram_dout_i  (sdout[g])
    );

    assign sdout[g] = {pipe[1][g], pipe[0][g]};

    initial begin
      for (int k = 0; k < 2; k++) begin
        for (int w = 0; w < 256; w++) mac[k][w] = 32'h0;
        for (int s = 0; s < 3; s++) pipe[k][s] = c_poison;
      end
    end

    // Macro behaviour: read data emerges g+1 edges after the select edge.
    always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
        pipe[k][2] <= pipe[k][1];
        pipe[k][1] <= pipe[k][0];
        if (!csb[g][k]) begin
          if (!web[g]) begin
            for (int b = 0; b < 4; b++)
              if (wmask[g][b]) mac[k][saddr[g]][8*b +: 8] <= sdin[g][8*b +: 8];
            pipe[k][0] <= c_poison;
          end else begin
            pipe[k][0] <= mac[k][saddr[g]];
          end
        end else begin
          pipe[k][0] <= c_poison;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a - c_base) < c_region;
  endfunction

  function automatic int gword(input logic [31:0] a);
    return int'((a - c_base) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, input logic [1:0] e_csb, input logic [7:0] e_addr,
                      input logic e_err, input int e_lat, input logic [31:0] e_rdat,
                      input string tag);
    int n;
    logic [31:0] e_dat;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
    @(posedge clk); #1;
    check({tag, "_csb"}, csb[d], e_csb);
    if (e_csb != 2'b11) check({tag, "_addr"}, saddr[d], e_addr);
    if (w && e_csb != 2'b11) check({tag, "_wr"}, {web[d], wmask[d], sdin[d]}, {1'b0, s, wd});
    n = 0;
    while (!(ack[d] || err[d]) && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(ack[d] || err[d])) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no response expected response after %0d cycles", tag, e_lat);
    end else begin
      check({tag, "_lat"}, n, e_lat);
      check({tag, "_resp"}, {ack[d], err[d]}, e_err ? 2'b01 : 2'b10);
      e_dat = (!e_err && !w) ? e_rdat : last_dat[d];
      check({tag, "_dat"}, rdat[d], e_dat);
      last_dat[d] = e_dat;
    end
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {ack[d], err[d]}, 2'b00);
    if (w && in_rng(a) && s != 4'h0) ref_mem[d][gword(a)] = merge(ref_mem[d][gword(a)], s, wd);
  endtask

  task automatic run_model(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] wd, input string tag);
    bit inr, skip;
    int gw;
    logic [1:0] e_csb;
    logic [31:0] e_rd;
    inr  = in_rng(a);
    skip = !inr || (w && s == 4'h0);
    gw   = 0;
    e_rd = 32'h0;
    if (inr) begin
      gw   = gword(a);
      e_rd = ref_mem[d][gw];
    end
    e_csb = skip ? 2'b11 : ((gw / 256) == 0 ? 2'b10 : 2'b01);
    xfer(d, w, a, s, wd, e_csb, 8'(gw % 256), c_err_en && skip,
         (!w && !skip) ? d + 2 : 2, e_rd, tag);
  endtask

  task automatic watch_silent(input int d, input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) seen = 1'b1;
    end
    check({tag, "_noresp"}, seen, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [1:0]  e_csb;
    logic [7:0]  e_addr;
    logic        e_err;
    logic        mrd;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 32'h3000_0404, 4'hF, 32'hDEAD_BEEF, 2'b01, 8'h01, 1'b0,     1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h3000_0404, 4'hF, 32'h0,         2'b01, 8'h01, 1'b0,     1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h3000_0008, 4'hF, 32'h0,         2'b10, 8'h02, 1'b0,     1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h3000_0008, 4'h5, 32'h1122_3344, 2'b10, 8'h02, 1'b0,     1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,         2'b10, 8'h02, 1'b0,     1'b1, 32'h0022_0044};
    tbl[5]  = '{1'b1, 32'h3000_07FC, 4'hF, 32'hA5A5_5A5A, 2'b01, 8'hFF, 1'b0,     1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h3000_07FF, 4'h0, 32'h0,         2'b01, 8'hFF, 1'b0,     1'b1, 32'hA5A5_5A5A};
    tbl[7]  = '{1'b0, 32'h3000_0800, 4'hF, 32'h0,         2'b11, 8'h00, c_err_en, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, 2'b11, 8'h00, c_err_en, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         2'b10, 8'h04, 1'b0,     1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h2FFF_FFFC, 4'hF, 32'h5555_AAAA, 2'b11, 8'h00, c_err_en, 1'b0, 32'h0};

    n_tests = 0;
    n_fail  = 0;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
      last_dat[d] = 32'h0;
      for (int w = 0; w < 512; w++) ref_mem[d][w] = 32'h0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_d%0d", d),
            {ack[d], err[d], rdat[d], csb[d], web[d], wmask[d], saddr[d], sdin[d]},
            {1'b0, 1'b0, 32'h0, 2'b11, 1'b1, 4'h0, 8'h0, 32'h0});

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 11; i++)
        xfer(d, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wdat, tbl[i].e_csb, tbl[i].e_addr,
             tbl[i].e_err, tbl[i].mrd ? d + 2 : 2, tbl[i].e_rdat, $sformatf("tbl%0d_d%0d", i, d));

    // Read abandoned one cycle into the macro wait, then a normal read.
    for (int d = 1; d < 3; d++) begin
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = 32'h3000_0404; sel[d] = 4'hF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      cyc[d] = 1'b0; stb[d] = 1'b0;
      watch_silent(d, 6, $sformatf("abort_rd_d%0d", d));
      check($sformatf("abort_rd_idle_d%0d", d), {csb[d], rdat[d]}, {2'b11, last_dat[d]});
      run_model(d, 1'b0, 32'h3000_0000, 4'hF, 32'h0, $sformatf("post_abort_d%0d", d));
    end

    // Write abandoned after issue still lands in the macro.
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = 32'h3000_0020; sel[d] = 4'hF;
      wdat[d] = 32'hDEAD_C0DE;
      @(posedge clk);
      @(negedge clk);
      cyc[d] = 1'b0; stb[d] = 1'b0;
      watch_silent(d, 5, $sformatf("abort_wr_d%0d", d));
      ref_mem[d][gword(32'h3000_0020)] = 32'hDEAD_C0DE;
      run_model(d, 1'b0, 32'h3000_0020, 4'hF, 32'h0, $sformatf("abort_wr_rb_d%0d", d));
    end

    // Reset asserted while a write is in flight.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h3000_0030; sel[0] = 4'hF;
    wdat[0] = 32'h1234_5678;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_write",
          {ack[0], err[0], rdat[0], csb[0], web[0], wmask[0], saddr[0], sdin[0]},
          {1'b0, 1'b0, 32'h0, 2'b11, 1'b1, 4'h0, 8'h0, 32'h0});
    for (int d = 0; d < 3; d++) last_dat[d] = 32'h0;
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_silent(0, 4, "rst_release");
    run_model(0, 1'b0, 32'h3000_0030, 4'hF, 32'h0, "rst_rb");

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 30; i++) begin
        logic [31:0] a;
        logic [3:0]  s;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      a = c_base + c_region + ($urandom_range(0, 255) << 2);
        else if (r == 1) a = c_base - 4 * $urandom_range(1, 16);
        else             a = c_base + ($urandom_range(0, 511) << 2) + $urandom_range(0, 3);
        s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        run_model(d, 1'($urandom), a, s, $urandom, $sformatf("rnd%0d_d%0d", i, d));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
